// File: rtl/ysyx_24090012_lsu_pkg.sv
// Shared constants for the load/store unit: opcodes, funct3 codes, FSM states
// and AXI response codes.
package ysyx_24090012_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AW_W = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Stores only have the three signed widths; loads add the two unsigned forms.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/ysyx_24090012_lsu_align.sv
// Byte-lane steering: store data replication and strobes, load extraction with
// sign/zero extension, and natural-alignment check. Purely combinational.
module ysyx_24090012_lsu_align
    import ysyx_24090012_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    // Lane steering and extension decoded from the access width.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        wdata     = store_data;
        wstrb     = 4'b1111;
        misalign  = 1'b0;

        // funct3[1:0] encodes the size for both loads and stores
        case (funct3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase

        case (funct3)
            F3_B: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << addr_lo;
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_24090012_lsu.sv
// Load/store unit between EXU and WBU. One instruction in flight: memory ops
// run a single AXI4-Lite read or write, everything else passes straight to WB.
module ysyx_24090012_lsu
    import ysyx_24090012_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] exu_inst,
    input  logic [31:0] exu_rd_data,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [31:0] wb_inst,
    output logic        wb_fault,
    output logic [31:0] lsu_count
);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] count_q, count_d;
    logic        wb_fault_q, wb_fault_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        idle;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_load;
    logic        al_misalign;
    logic        in_load;
    logic        in_store;
    logic        in_bad;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner looks at the incoming instruction (to classify it and
    // precompute store lanes); afterwards it looks at the latched copy for loads.
    assign al_funct3  = idle ? exu_inst[14:12] : inst_q[14:12];
    assign al_addr_lo = idle ? mem_addr[1:0] : addr_q[1:0];

    ysyx_24090012_lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (mem_wdata),
        .rdata      (rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    assign in_load  = (exu_inst[6:0] == OP_LOAD);
    assign in_store = (exu_inst[6:0] == OP_STORE);
    assign in_bad   = al_misalign | ~f3_legal(in_load, exu_inst[14:12]);

    // Next-state and datapath capture for the single-instruction FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wb_data_d  = wb_data_q;
        wb_fault_d = wb_fault_q;
        count_d    = count_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d     = mem_addr;
                    inst_d     = exu_inst;
                    wdata_d    = al_wdata;
                    wstrb_d    = al_wstrb;
                    wb_data_d  = 32'b0;
                    wb_fault_d = 1'b0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    if (in_load || in_store) begin
                        if (in_bad) begin
                            wb_fault_d = 1'b1;
                            state_d    = ST_WB;
                        end else begin
                            state_d = in_load ? ST_AR : ST_AW_W;
                        end
                    end else begin
                        wb_data_d = exu_rd_data;
                        state_d   = ST_WB;
                    end
                end
            end
            ST_AR: begin
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                if (rvalid) begin
                    if (rresp != RESP_OKAY) begin
                        wb_fault_d = 1'b1;
                        wb_data_d  = 32'b0;
                    end else begin
                        wb_data_d = al_load;
                    end
                    state_d = ST_WB;
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    wb_fault_d = (bresp != RESP_OKAY);
                    wb_data_d  = 32'b0;
                    state_d    = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    count_d = count_q + 32'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any bus transaction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'b0;
            inst_q     <= 32'b0;
            wdata_q    <= 32'b0;
            wstrb_q    <= 4'b0;
            wb_data_q  <= 32'b0;
            wb_fault_q <= 1'b0;
            count_q    <= 32'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_data_q  <= wb_data_d;
            wb_fault_q <= wb_fault_d;
            count_q    <= count_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign mem_ready = idle;
    assign araddr    = {addr_q[31:2], 2'b00};
    assign arvalid   = (state_q == ST_AR);
    assign rready    = (state_q == ST_R);
    assign awaddr    = {addr_q[31:2], 2'b00};
    assign awvalid   = (state_q == ST_AW_W) & ~aw_done_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = (state_q == ST_AW_W) & ~w_done_q;
    assign bready    = (state_q == ST_B);
    assign wb_valid  = (state_q == ST_WB);
    assign wb_data   = wb_data_q;
    assign wb_inst   = inst_q;
    assign wb_fault  = wb_fault_q;
    assign lsu_count = count_q;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Randomized bench for the LSU: a reactive AXI4-Lite slave with programmable
// wait states, and a behavioural model of each instruction's result and timing.
module tb_ysyx_24090012_lsu;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] exu_inst;
    logic [31:0] exu_rd_data;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [31:0] wb_inst;
    logic        wb_fault;
    logic [31:0] lsu_count;

    ysyx_24090012_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .exu_inst    (exu_inst),
        .exu_rd_data (exu_rd_data),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_inst     (wb_inst),
        .wb_fault    (wb_fault),
        .lsu_count   (lsu_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_count = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave configuration written by the stimulus, read by the slave.
    int          cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
    logic [31:0] cfg_rdata = 32'b0;
    logic [1:0]  cfg_rresp = 2'b0, cfg_bresp = 2'b0;

    // Slave bookkeeping, written only by the slave process.
    int          ar_age = 0, r_age = 0, aw_age = 0, w_age = 0, b_age = 0;
    bit          r_pend = 0, aw_got = 0, w_got = 0;
    int          ar_n = 0, aw_n = 0, w_n = 0, proto_err = 0;
    logic [31:0] ar_addr_log = 32'b0, aw_addr_log = 32'b0, w_data_log = 32'b0;
    logic [3:0]  w_strb_log = 4'b0;

    // Reactive slave: decides readies/valids at negedge, so every handshake it
    // grants here completes on the following posedge.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'b0; rresp = 2'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                r_pend = 0; aw_got = 0; w_got = 0;
                ar_age = 0; r_age = 0; aw_age = 0; w_age = 0; b_age = 0;
            end else begin
                if (r_pend) begin
                    if (r_age < cfg_r_wait) begin
                        r_age++;
                        rvalid = 1'b0;
                    end else begin
                        rvalid = 1'b1;
                        rdata  = cfg_rdata;
                        rresp  = cfg_rresp;
                        if (rready) begin
                            r_pend = 0;
                            r_age  = 0;
                        end
                    end
                end else begin
                    rvalid = 1'b0;
                end
                if (arvalid) begin
                    if (ar_age < cfg_ar_wait) begin
                        ar_age++;
                        arready = 1'b0;
                    end else begin
                        arready     = 1'b1;
                        ar_n++;
                        ar_addr_log = araddr;
                        r_pend      = 1;
                        ar_age      = 0;
                    end
                end else begin
                    arready = 1'b0;
                end
                if (aw_got && w_got) begin
                    if (b_age < cfg_b_wait) begin
                        b_age++;
                        bvalid = 1'b0;
                    end else begin
                        bvalid = 1'b1;
                        bresp  = cfg_bresp;
                        if (bready) begin
                            aw_got = 0;
                            w_got  = 0;
                            b_age  = 0;
                        end
                    end
                end else begin
                    bvalid = 1'b0;
                    if (bready) proto_err++;
                end
                if (awvalid) begin
                    if (aw_got) proto_err++;
                    if (aw_age < cfg_aw_wait) begin
                        aw_age++;
                        awready = 1'b0;
                    end else begin
                        awready     = 1'b1;
                        aw_n++;
                        aw_addr_log = awaddr;
                        aw_got      = 1;
                        aw_age      = 0;
                    end
                end else begin
                    awready = 1'b0;
                end
                if (wvalid) begin
                    if (w_got) proto_err++;
                    if (w_age < cfg_w_wait) begin
                        w_age++;
                        wready = 1'b0;
                    end else begin
                        wready     = 1'b1;
                        w_n++;
                        w_data_log = wdata;
                        w_strb_log = wstrb;
                        w_got      = 1;
                        w_age      = 0;
                    end
                end else begin
                    wready = 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h00a5a, f3, 5'd7, opc};
    endfunction

    // Architectural model. kind: 0 passthrough, 1 load, 2 store, 3 faulted before bus.
    function automatic void model(input logic [31:0] inst, input logic [31:0] addr,
                                  input logic [31:0] sdata, input logic [31:0] rd,
                                  input logic [31:0] rdat, input logic [1:0] rr,
                                  input logic [1:0] br, output int kind,
                                  output logic [31:0] exp_data, output logic exp_fault,
                                  output logic [31:0] exp_wdata, output logic [3:0] exp_wstrb);
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          bytes;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        bit          legal;
        opc       = inst[6:0];
        f3        = inst[14:12];
        bytes     = 1 << f3[1:0];
        off       = int'(addr % 4);
        mask      = (bytes >= 4) ? 32'hffff_ffff : ((32'h1 << (8 * bytes)) - 32'h1);
        exp_wdata = 32'b0;
        exp_wstrb = 4'b0;
        exp_data  = 32'b0;
        exp_fault = 1'b0;
        kind      = 0;
        if (opc == 7'b0000011 || opc == 7'b0100011) begin
            if (opc == 7'b0000011) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            else                   legal = (f3 <= 2);
            if (!legal || (off % bytes) != 0) begin
                kind      = 3;
                exp_fault = 1'b1;
            end else if (opc == 7'b0000011) begin
                kind = 1;
                if (rr != 2'b00) begin
                    exp_fault = 1'b1;
                end else begin
                    val = (rdat >> (8 * off)) & mask;
                    if (!f3[2] && bytes < 4 && val[8 * bytes - 1]) val = val | ~mask;
                    exp_data = val;
                end
            end else begin
                kind      = 2;
                exp_fault = (br != 2'b00);
                if (bytes == 1)      exp_wdata = (sdata & 32'hff) * 32'h0101_0101;
                else if (bytes == 2) exp_wdata = (sdata & 32'hffff) * 32'h0001_0001;
                else                 exp_wdata = sdata;
                exp_wstrb = 4'(((1 << bytes) - 1) << off);
            end
        end else begin
            exp_data = rd;
        end
    endfunction

    // Issue one instruction, wait for its result, hold wb_ready low `hold`
    // cycles, then retire it. Called at posedge+1.
    task automatic run(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rd,
                       input logic [31:0] rdat, input logic [1:0] rr,
                       input logic [1:0] br, input int hold);
        int          kind;
        logic [31:0] e_data, e_wdata;
        logic        e_fault;
        logic [3:0]  e_wstrb;
        int          e_lat, lat, n, ar0, aw0, w0;
        model(inst, addr, sdata, rd, rdat, rr, br, kind, e_data, e_fault, e_wdata, e_wstrb);
        case (kind)
            1:       e_lat = 2 + cfg_ar_wait + cfg_r_wait;
            2:       e_lat = 2 + ((cfg_aw_wait > cfg_w_wait) ? cfg_aw_wait : cfg_w_wait) + cfg_b_wait;
            default: e_lat = 0;
        endcase
        cfg_rdata = rdat;
        cfg_rresp = rr;
        cfg_bresp = br;
        ar0 = ar_n; aw0 = aw_n; w0 = w_n;
        n = 0;
        while (!mem_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("mem_ready_before_issue", 32'(mem_ready), 32'd1);
        mem_valid   = 1'b1;
        mem_addr    = addr;
        mem_wdata   = sdata;
        exu_inst    = inst;
        exu_rd_data = rd;
        @(posedge clk); #1;
        // Inputs after accept must be ignored: scramble them.
        mem_valid   = 1'b0;
        mem_addr    = $urandom();
        mem_wdata   = $urandom();
        exu_inst    = $urandom();
        exu_rd_data = $urandom();
        lat = 0;
        while (!wb_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("wb_valid_seen", 32'(wb_valid), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("wb_data", wb_data, e_data);
        check("wb_fault", 32'(wb_fault), 32'(e_fault));
        check("wb_inst", wb_inst, inst);
        check("mem_ready_busy", 32'(mem_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(wb_valid), 32'd1);
            check("hold_data", wb_data, e_data);
            check("hold_inst", wb_inst, inst);
            check("hold_ready", 32'(mem_ready), 32'd0);
        end
        if (kind == 1) begin
            check("ar_count", 32'(ar_n - ar0), 32'd1);
            check("araddr", ar_addr_log, addr & 32'hffff_fffc);
        end else if (kind == 2) begin
            check("aw_count", 32'(aw_n - aw0), 32'd1);
            check("w_count", 32'(w_n - w0), 32'd1);
            check("awaddr", aw_addr_log, addr & 32'hffff_fffc);
            check("wdata", w_data_log, e_wdata);
            check("wstrb", 32'(w_strb_log), 32'(e_wstrb));
        end else begin
            check("no_bus", 32'((ar_n - ar0) + (aw_n - aw0) + (w_n - w0)), 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready  = 1'b0;
        exp_count = exp_count + 32'd1;
        check("lsu_count", lsu_count, exp_count);
        check("wb_valid_drop", 32'(wb_valid), 32'd0);
    endtask

    task automatic zero_waits();
        cfg_ar_wait = 0; cfg_r_wait = 0; cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0;
    endtask

    initial begin
        logic [31:0] inst, addr, r32;
        logic [1:0]  rr, br;
        int          sel, n;

        rst = 1'b0; mem_valid = 1'b0; mem_addr = 32'b0; mem_wdata = 32'b0;
        exu_inst = 32'b0; exu_rd_data = 32'b0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_inst", wb_inst, 32'd0);
        check("rst_wb_fault", 32'(wb_fault), 32'd0);
        check("rst_lsu_count", lsu_count, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the feature list.
        zero_waits();
        run(mk_inst(7'b0010011, 3'b000), 32'h0000_1000, 32'h0, 32'h1234_5678, 32'h0, 2'b00, 2'b00, 0);
        run(mk_inst(7'b0000011, 3'b000), 32'h8000_0003, 32'h0, 32'h0, 32'h80ff_0000, 2'b00, 2'b00, 0);
        run(mk_inst(7'b0000011, 3'b100), 32'h8000_0003, 32'h0, 32'h0, 32'h80ff_0000, 2'b00, 2'b00, 0);
        cfg_w_wait = 1;
        run(mk_inst(7'b0100011, 3'b001), 32'h8000_0002, 32'h0000_beef, 32'h0, 32'h0, 2'b00, 2'b00, 0);
        zero_waits();
        run(mk_inst(7'b0000011, 3'b010), 32'h8000_0001, 32'h0, 32'h0, 32'hdead_beef, 2'b00, 2'b00, 0);
        run(mk_inst(7'b0000011, 3'b010), 32'h8000_0004, 32'h0, 32'h0, 32'hdead_beef, 2'b10, 2'b00, 0);
        run(mk_inst(7'b0100011, 3'b010), 32'h8000_0008, 32'hcafe_f00d, 32'h0, 32'h0, 2'b00, 2'b11, 0);
        run(mk_inst(7'b0110011, 3'b000), 32'h0, 32'h0, 32'h0bad_cafe, 32'h0, 2'b00, 2'b00, 5);

        // Reset while the load sits in R waiting for data.
        cfg_r_wait  = 20;
        mem_valid   = 1'b1;
        mem_addr    = 32'h8000_0010;
        exu_inst    = mk_inst(7'b0000011, 3'b010);
        exu_rd_data = 32'h0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        n = 0;
        while (!rready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rready_before_reset", 32'(rready), 32'd1);
        #1 rst = 1'b0;
        #1;
        exp_count = 32'd0;
        check("rst_async_rready", 32'(rready), 32'd0);
        check("rst_async_arvalid", 32'(arvalid), 32'd0);
        check("rst_async_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_async_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_async_count", lsu_count, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        zero_waits();
        @(posedge clk); #1;
        run(mk_inst(7'b0000011, 3'b001), 32'h8000_0012, 32'h0, 32'h0, 32'h8001_7fff, 2'b00, 2'b00, 0);

        // Random mix of passthrough, loads and stores with random wait states.
        for (int it = 0; it < 250; it++) begin
            inst = $urandom();
            sel  = $urandom_range(0, 9);
            if (sel < 4)      inst[6:0] = 7'b0000011;
            else if (sel < 8) inst[6:0] = 7'b0100011;
            else              inst[6:0] = (sel == 8) ? 7'b0010011 : 7'b0110111;
            r32  = $urandom();
            inst[14:12] = (r32[3:2] != 2'b00) ? {1'b0, 1'b0, r32[0]} | {r32[4] & (sel < 4), 1'b0, 1'b0}
                                              : r32[7:5];
            addr = $urandom();
            r32  = $urandom();
            rr   = (r32[2:0] == 3'd0) ? r32[4:3] | 2'b01 : 2'b00;
            br   = (r32[7:5] == 3'd0) ? r32[9:8] | 2'b10 : 2'b00;
            cfg_ar_wait = $urandom_range(0, 3);
            cfg_r_wait  = $urandom_range(0, 3);
            cfg_aw_wait = $urandom_range(0, 3);
            cfg_w_wait  = $urandom_range(0, 3);
            cfg_b_wait  = $urandom_range(0, 2);
            run(inst, addr, $urandom(), $urandom(), $urandom(), rr, br, $urandom_range(0, 2));
        end

        check("axi_protocol", 32'(proto_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
